kernel_bc_fifo_srl_flex: RTL and testbench

Parametrised shift-register FIFO for inter-process streams in the kernel_bc dataflow region; it generalises the fixed-width, fixed-depth w64_d3 stream FIFO. Adds arbitrary width and depth, an occupancy count, programmable almost-full and almost-empty flags, a synchronous flush, and an optional registered output stage. It keeps the existing `if_*` ap_fifo handshake, so producer and consumer processes connect unchanged.

---
 rtl/kernel_bc_fifo_pkg.sv | 26 ++
 rtl/kernel_bc_fifo_srl_mem.sv | 29 ++
 rtl/kernel_bc_fifo_srl_flex.sv | 142 ++++++++++++++
 tb/tb_kernel_bc_fifo_srl_flex.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/kernel_bc_fifo_pkg.sv
// Shared helpers for the kernel_bc stream FIFOs: clog2, occupancy width rule
// and default almost-full/almost-empty margins.
package kernel_bc_fifo_pkg;

    localparam int OCC_EXTRA_BITS    = 2;
    localparam int DEFAULT_AF_MARGIN = 1;
    localparam int DEFAULT_AE_MARGIN = 1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // Occupancy must reach DEPTH+1 when the output register is present.
    function automatic int occWidth(input int addrWidth);
        return addrWidth + OCC_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/kernel_bc_fifo_srl_mem.sv
// Data-only shift register for kernel_bc_fifo_srl_flex: entry 0 takes the new
// word on ce, q reads entry a. Contents are never reset.
module kernel_bc_fifo_srl_mem #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 3,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] r_srl [DEPTH];

    always_ff @(posedge clk) begin
        if (ce) begin
            r_srl[0] <= data;
            for (int i = 1; i < DEPTH; i++) begin
                r_srl[i] <= r_srl[i-1];
            end
        end
    end

    // Addresses past DEPTH only occur when empty, where q is a don't-care.
    assign q = (int'(a) < DEPTH) ? r_srl[a] : '0;

endmodule

// File: rtl/kernel_bc_fifo_srl_flex.sv
// Parametrised shift-register stream FIFO with occupancy, almost flags and flush.
// Define KERNEL_BC_FIFO_OUTREG_EN to add a registered output word (CAP = DEPTH+1).
module kernel_bc_fifo_srl_flex
    import kernel_bc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 3,
    parameter int ADDR_WIDTH = 2,
    parameter int AF_MARGIN  = DEFAULT_AF_MARGIN,
    parameter int AE_MARGIN  = DEFAULT_AE_MARGIN
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_write_ce,
    input  logic                    if_write,
    input  logic [DATA_WIDTH-1:0]   if_din,
    output logic                    if_full_n,
    input  logic                    if_read_ce,
    input  logic                    if_read,
    output logic [DATA_WIDTH-1:0]   if_dout,
    output logic                    if_empty_n,
    input  logic                    if_flush,
    output logic [ADDR_WIDTH+1:0]   if_num_data_valid,
    output logic                    if_almost_full_n,
    output logic                    if_almost_empty_n
);

    localparam int OCC_W = occWidth(ADDR_WIDTH);
`ifdef KERNEL_BC_FIFO_OUTREG_EN
    localparam int CAP = DEPTH + 1;
`else
    localparam int CAP = DEPTH;
`endif
    localparam logic [OCC_W-1:0] CAP_V = OCC_W'(CAP);
    localparam logic [OCC_W-1:0] AF_V  = OCC_W'(AF_MARGIN);
    localparam logic [OCC_W-1:0] AE_V  = OCC_W'(AE_MARGIN);
    localparam logic [OCC_W-1:0] ONE   = OCC_W'(1);

    logic [OCC_W-1:0]      r_cnt, r_occ, w_cntNext, w_occNext;
    logic                  r_emptyN, r_fullN, r_almostEmptyN, r_almostFullN;
    logic                  w_push, w_pop, w_memCe;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_memQ;

    assign w_push = if_write & if_write_ce & r_fullN;
    assign w_pop  = if_read  & if_read_ce  & r_emptyN;
    assign w_addr = ADDR_WIDTH'(r_cnt - ONE);

`ifdef KERNEL_BC_FIFO_OUTREG_EN
    logic                  r_outValid, w_outValidNext, w_bypass, w_refill;
    logic [DATA_WIDTH-1:0] r_dout;

    // A write lands straight in the output word when storage has nothing older.
    assign w_bypass = w_push & (r_cnt == '0) & (~r_outValid | w_pop);
    assign w_refill = w_pop & (r_cnt != '0);
    assign w_memCe  = w_push & ~w_bypass & ~if_flush & ~reset;

    always_comb begin
        w_cntNext      = r_cnt;
        w_outValidNext = r_outValid;
        if (w_push && !w_bypass && !w_refill) begin
            w_cntNext = r_cnt + ONE;
        end else if (w_refill && !w_push) begin
            w_cntNext = r_cnt - ONE;
        end
        if (w_bypass || w_refill) begin
            w_outValidNext = 1'b1;
        end else if (w_pop) begin
            w_outValidNext = 1'b0;
        end
        w_occNext = w_cntNext + OCC_W'(w_outValidNext);
    end

    always_ff @(posedge clk) begin
        if (reset || if_flush) begin
            r_outValid <= 1'b0;
            r_dout     <= '0;
        end else begin
            r_outValid <= w_outValidNext;
            if (w_bypass) begin
                r_dout <= if_din;
            end else if (w_refill) begin
                r_dout <= w_memQ;
            end
        end
    end

    assign if_dout = r_dout;
`else
    assign w_memCe = w_push & ~if_flush & ~reset;

    always_comb begin
        w_cntNext = r_cnt;
        if (w_push && !w_pop) begin
            w_cntNext = r_cnt + ONE;
        end else if (w_pop && !w_push) begin
            w_cntNext = r_cnt - ONE;
        end
        w_occNext = w_cntNext;
    end

    assign if_dout = w_memQ;
`endif

    // Flush behaves exactly like reset for the counters and every flag.
    always_ff @(posedge clk) begin
        if (reset || if_flush) begin
            r_cnt          <= '0;
            r_occ          <= '0;
            r_emptyN       <= 1'b0;
            r_fullN        <= 1'b1;
            r_almostEmptyN <= 1'b0;
            r_almostFullN  <= 1'b1;
        end else begin
            r_cnt          <= w_cntNext;
            r_occ          <= w_occNext;
            r_emptyN       <= (w_occNext != '0);
            r_fullN        <= (w_occNext != CAP_V);
            r_almostEmptyN <= (w_occNext > AE_V);
            r_almostFullN  <= ((CAP_V - w_occNext) > AF_V);
        end
    end

    kernel_bc_fifo_srl_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .ce   (w_memCe),
        .data (if_din),
        .a    (w_addr),
        .q    (w_memQ)
    );

    assign if_full_n         = r_fullN;
    assign if_empty_n        = r_emptyN;
    assign if_almost_full_n  = r_almostFullN;
    assign if_almost_empty_n = r_almostEmptyN;
    assign if_num_data_valid = r_occ;

endmodule

// File: tb/tb_kernel_bc_fifo_srl_flex.sv
// Scoreboard bench for kernel_bc_fifo_srl_flex (DEPTH=4); follows
// KERNEL_BC_FIFO_OUTREG_EN for the expected capacity.
module tb_kernel_bc_fifo_srl_flex;

`ifdef KERNEL_BC_FIFO_OUTREG_EN
    localparam int CAP = 5;
`else
    localparam int CAP = 4;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        if_write_ce, if_write, if_read_ce, if_read, if_flush;
    logic [63:0] if_din, if_dout;
    logic        if_full_n, if_empty_n, if_almost_full_n, if_almost_empty_n;
    logic [3:0]  if_num_data_valid;

    int          nCompared = 0;
    int          nMismatch = 0;
    logic [63:0] expQ [$];
    logic [63:0] fillData [5] = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h50};

    always #5 clk = ~clk;

    kernel_bc_fifo_srl_flex #(
        .DATA_WIDTH (64),
        .DEPTH      (4),
        .ADDR_WIDTH (2),
        .AF_MARGIN  (1),
        .AE_MARGIN  (1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .if_write_ce       (if_write_ce),
        .if_write          (if_write),
        .if_din            (if_din),
        .if_full_n         (if_full_n),
        .if_read_ce        (if_read_ce),
        .if_read           (if_read),
        .if_dout           (if_dout),
        .if_empty_n        (if_empty_n),
        .if_flush          (if_flush),
        .if_num_data_valid (if_num_data_valid),
        .if_almost_full_n  (if_almost_full_n),
        .if_almost_empty_n (if_almost_empty_n)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Expected flags for a given occupancy with AF_MARGIN = AE_MARGIN = 1.
    task automatic checkStatus(input string tag, input int occ);
        checkOutput({tag, ".num"},     64'(if_num_data_valid), 64'(occ));
        checkOutput({tag, ".emptyN"},  64'(if_empty_n),        64'(occ != 0));
        checkOutput({tag, ".fullN"},   64'(if_full_n),         64'(occ != CAP));
        checkOutput({tag, ".aFullN"},  64'(if_almost_full_n),  64'((CAP - occ) > 1));
        checkOutput({tag, ".aEmptyN"}, 64'(if_almost_empty_n), 64'(occ > 1));
    endtask

    task automatic applyStimulus(input logic wr, input logic [63:0] din, input logic rd, input logic fl);
        if_write = wr;
        if_din   = din;
        if_read  = rd;
        if_flush = fl;
        @(posedge clk);
        #1;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_flush = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        if_write_ce = 1'b1;
        if_read_ce  = 1'b1;
        if_write    = 1'b0;
        if_read     = 1'b0;
        if_flush    = 1'b0;
        if_din      = '0;

        // Monitor: pops the scoreboard whenever the DUT accepts a read.
        fork
            forever begin
                @(negedge clk);
                if (!reset && !if_flush && if_read && if_read_ce && if_empty_n) begin
                    nCompared++;
                    if (expQ.size() == 0) begin
                        nMismatch++;
                        $display("[TB] FAIL readData: got %0h while no word expected", if_dout);
                    end else begin
                        logic [63:0] expWord;
                        expWord = expQ.pop_front();
                        if (if_dout !== expWord) begin
                            nMismatch++;
                            $display("[TB] FAIL readData: got %0h expected %0h", if_dout, expWord);
                        end
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkStatus("reset", 0);

        for (int k = 0; k < CAP; k++) begin
            expQ.push_back(fillData[k]);
            applyStimulus(1'b1, fillData[k], 1'b0, 1'b0);
            checkStatus($sformatf("fill%0d", k + 1), k + 1);
            if (k == 0) checkOutput("firstWordLatency", if_dout, 64'h11);
        end

        applyStimulus(1'b1, 64'h55, 1'b0, 1'b0);
        checkStatus("writeWhenFull", CAP);

        for (int k = 0; k < CAP; k++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkStatus($sformatf("drain%0d", k + 1), CAP - 1 - k);
        end

        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkStatus("readWhenEmpty", 0);

        expQ.push_back(64'hA0);
        applyStimulus(1'b1, 64'hA0, 1'b0, 1'b0);
        expQ.push_back(64'hA1);
        applyStimulus(1'b1, 64'hA1, 1'b0, 1'b0);
        checkStatus("held2", 2);

        if_read_ce = 1'b0;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        if_read_ce = 1'b1;
        checkStatus("readStall", 2);
        if_write_ce = 1'b0;
        applyStimulus(1'b1, 64'hEE, 1'b0, 1'b0);
        if_write_ce = 1'b1;
        checkStatus("writeStall", 2);

        for (int i = 0; i < 10; i++) begin
            expQ.push_back(64'hB0 + 64'(i));
            applyStimulus(1'b1, 64'hB0 + 64'(i), 1'b1, 1'b0);
            checkStatus($sformatf("readWrite%0d", i), 2);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkStatus("streamDrained", 0);

        for (int i = 0; i < 3; i++) begin
            expQ.push_back(64'hC0 + 64'(i));
            applyStimulus(1'b1, 64'hC0 + 64'(i), 1'b0, 1'b0);
        end
        checkStatus("held3", 3);
        applyStimulus(1'b1, 64'h99, 1'b0, 1'b1);
        expQ.delete();
        checkStatus("flush", 0);
        expQ.push_back(64'hD0);
        applyStimulus(1'b1, 64'hD0, 1'b0, 1'b0);
        checkOutput("postFlushHead", if_dout, 64'hD0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkStatus("postFlushRead", 0);

        expQ.push_back(64'hE0);
        applyStimulus(1'b1, 64'hE0, 1'b0, 1'b0);
        expQ.push_back(64'hE1);
        applyStimulus(1'b1, 64'hE1, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expQ.delete();
        checkStatus("midReset", 0);
`ifdef KERNEL_BC_FIFO_OUTREG_EN
        checkOutput("midResetDout", if_dout, 64'h0);
`endif
        expQ.push_back(64'hF0);
        applyStimulus(1'b1, 64'hF0, 1'b0, 1'b0);
        checkOutput("postResetHead", if_dout, 64'hF0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkStatus("postResetRead", 0);

        checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
